// File: rtl/psum_column_drain.sv
// psum_column_drain: reader at the bottom of one systolic PE column.
// On start it shifts the column's partial sums down the in_sum/out_sum chain,
// captures each value leaving the bottom PE into a small first-word-fall-through
// FIFO, and presents the captured sums on a valid/ready stream, bottom row first.
// Optional feature macro: PSUM_DRAIN_TAG_EN adds the m_tag port (row index per value).
module psum_column_drain #(
    parameter int DATA_WIDTH = 19,
    parameter int ROWS       = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int TAG_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    col_w_en,
    output logic [2*DATA_WIDTH-1:0] col_sum_top,
    input  logic [2*DATA_WIDTH-1:0] col_sum_tail,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [2*DATA_WIDTH-1:0] m_data
`ifdef PSUM_DRAIN_TAG_EN
    ,
    output logic [TAG_W-1:0]        m_tag
`endif
);

    localparam int SW    = 2 * DATA_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [TAG_W-1:0]   cap_cnt_q, cap_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [SW-1:0]      data_mem [FIFO_DEPTH];

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [TAG_W-1:0]   cur_tag;

    assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    // The shift enable doubles as the capture strobe: the tail value present
    // before the shift is the one pushed. Held low while in reset.
    assign col_w_en    = !rst && (state_q == S_DRAIN) && !fifo_full;
    assign push        = col_w_en;
    assign pop         = !fifo_empty && m_ready;
    assign cur_tag     = TAG_W'(ROWS - 1) - cap_cnt_q;

    assign col_sum_top = '0;
    assign busy        = busy_q;
    assign done        = done_q;
    assign m_valid     = !fifo_empty;
    assign m_data      = data_mem[rd_ptr_q];

    // Next-state logic for the drain sequencer and FIFO bookkeeping.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cap_cnt_d = cap_cnt_q;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_DRAIN;
                    busy_d    = 1'b1;
                    cap_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                if (push) begin
                    cap_cnt_d = cap_cnt_q + 1'b1;
                    if (cap_cnt_q == TAG_W'(ROWS - 1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // No pushes happen here, so a pop of the last entry empties it.
                if (pop && (count_q == CNT_W'(1))) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state, registered status outputs and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cap_cnt_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cap_cnt_q <= cap_cnt_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Capture storage; contents are don't-care until the count marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= col_sum_tail;
        end
    end

`ifdef PSUM_DRAIN_TAG_EN
    logic [TAG_W-1:0] tag_mem [FIFO_DEPTH];

    // Row index stored alongside each captured sum.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= cur_tag;
        end
    end

    assign m_tag = tag_mem[rd_ptr_q];
`else
    logic unused_tag;
    assign unused_tag = ^cur_tag;
`endif

endmodule
